// File: rtl/img_stream_gen.sv
// Raster pixel source: runs N frames per start, with a frame gap before each frame and
// optional line blanking. Pixels come from an external ready/valid stream or an internal
// ramp, constant or checker pattern.
module img_stream_gen #(
   parameter int unsigned IMG_WIDTH  = 120,
   parameter int unsigned IMG_HEIGHT = 100,
   parameter int unsigned PIX_W      = 8,
   parameter int unsigned CNT_W      = 10,
   parameter int unsigned FRAME_GAP  = 1000,
   parameter int unsigned LINE_GAP   = 0,
   parameter int unsigned NFRM_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [NFRM_W-1:0] num_frames,
   input  logic [PIX_W-1:0]  pattern_val,
   input  logic [PIX_W-1:0]  src_data,
   input  logic              src_valid,
   output logic              src_ready,
   output logic [PIX_W-1:0]  img_dout,
   output logic              img_dout_valid,
   output logic [CNT_W-1:0]  col_cnt,
   output logic [CNT_W-1:0]  row_cnt,
   output logic              sof,
   output logic              eol,
   output logic              eof,
   output logic              frame_id,
   output logic              busy,
   output logic              done
);

   localparam int unsigned GAP_MAX = (FRAME_GAP > LINE_GAP) ? FRAME_GAP : LINE_GAP;
   localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
   localparam int unsigned CHK_B   = (CNT_W > 3) ? 3 : CNT_W - 1;
   localparam bit          HAS_LGAP = (LINE_GAP != 0);

   localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMG_WIDTH - 1);
   localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(IMG_HEIGHT - 1);
   localparam logic [GAP_W-1:0] FGAP_INIT = GAP_W'(FRAME_GAP - 1);
   localparam logic [GAP_W-1:0] LGAP_INIT = GAP_W'(HAS_LGAP ? LINE_GAP - 1 : 0);

   localparam logic [1:0] MODE_EXT   = 2'd0;
   localparam logic [1:0] MODE_RAMP  = 2'd1;
   localparam logic [1:0] MODE_CONST = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FGAP,
      S_ACTIVE,
      S_LGAP,
      S_DONE
   } state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  col, col_n;
   logic [CNT_W-1:0]  row, row_n;
   logic [GAP_W-1:0]  gap, gap_n;
   logic [NFRM_W-1:0] frm_left, frm_left_n;
   logic              fid, fid_n;
   logic [1:0]        run_mode, run_mode_n;
   logic [PIX_W-1:0]  run_pat, run_pat_n;

   logic              ext_sel;
   logic              fire;
   logic [CNT_W:0]    ramp_sum;
   logic [PIX_W-1:0]  pix;

   assign ext_sel   = (run_mode == MODE_EXT);
   assign src_ready = (state == S_ACTIVE) && ext_sel;

   // State, raster counters and run configuration registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         col      <= '0;
         row      <= '0;
         gap      <= '0;
         frm_left <= '0;
         fid      <= 1'b0;
         run_mode <= '0;
         run_pat  <= '0;
      end else begin
         state    <= state_n;
         col      <= col_n;
         row      <= row_n;
         gap      <= gap_n;
         frm_left <= frm_left_n;
         fid      <= fid_n;
         run_mode <= run_mode_n;
         run_pat  <= run_pat_n;
      end
   end

   // Next-state logic: gaps, raster walk, frame sequencing
   always_comb begin
      state_n    = state;
      col_n      = col;
      row_n      = row;
      gap_n      = gap;
      frm_left_n = frm_left;
      fid_n      = fid;
      run_mode_n = run_mode;
      run_pat_n  = run_pat;
      fire       = 1'b0;

      case (state)
         S_IDLE: begin
            // A start coinciding with the done pulse is dropped
            if (start && !done) begin
               state_n    = S_FGAP;
               gap_n      = FGAP_INIT;
               col_n      = '0;
               row_n      = '0;
               fid_n      = 1'b0;
               run_mode_n = mode;
               run_pat_n  = pattern_val;
               frm_left_n = (num_frames == '0) ? '0 : num_frames - NFRM_W'(1);
            end
         end

         S_FGAP, S_LGAP: begin
            if (gap == '0) begin
               state_n = S_ACTIVE;
            end else begin
               gap_n = gap - GAP_W'(1);
            end
         end

         S_ACTIVE: begin
            fire = !ext_sel || src_valid;
            if (fire) begin
               if (col == COL_LAST) begin
                  col_n = '0;
                  if (row == ROW_LAST) begin
                     row_n = '0;
                     if (frm_left != '0) begin
                        frm_left_n = frm_left - NFRM_W'(1);
                        fid_n      = ~fid;
                        state_n    = S_FGAP;
                        gap_n      = FGAP_INIT;
                     end else begin
                        state_n = S_DONE;
                     end
                  end else begin
                     row_n = row + CNT_W'(1);
                     if (HAS_LGAP) begin
                        state_n = S_LGAP;
                        gap_n   = LGAP_INIT;
                     end
                  end
               end else begin
                  col_n = col + CNT_W'(1);
               end
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Pixel value for the current raster position
   always_comb begin
      ramp_sum = {1'b0, col} + {1'b0, row};
      case (run_mode)
         MODE_EXT:   pix = src_data;
         MODE_RAMP:  pix = PIX_W'(ramp_sum);
         MODE_CONST: pix = run_pat;
         default:    pix = (col[CHK_B] ^ row[CHK_B]) ? '1 : '0;
      endcase
   end

   // Output register: pixel plus sideband, held while no pixel is emitted
   always_ff @(posedge clk) begin
      if (!rst) begin
         img_dout       <= '0;
         img_dout_valid <= 1'b0;
         col_cnt        <= '0;
         row_cnt        <= '0;
         sof            <= 1'b0;
         eol            <= 1'b0;
         eof            <= 1'b0;
         frame_id       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         img_dout_valid <= fire;
         busy           <= (state_n != S_IDLE);
         done           <= (state == S_DONE);
         if (fire) begin
            img_dout <= pix;
            col_cnt  <= col;
            row_cnt  <= row;
            sof      <= (col == '0) && (row == '0);
            eol      <= (col == COL_LAST);
            eof      <= (col == COL_LAST) && (row == ROW_LAST);
            frame_id <= fid;
         end
      end
   end

endmodule
